// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Instruction fetch stage driving bus 0 of the dual-port memory and feeding
// decode. Issues sequential word-aligned fetches, hides the memory's
// one-cycle read latency behind a 2-entry instruction queue, and handles
// decode backpressure and branch/jump redirects.
//
// Ports:
//   clk            rising-edge clock
//   rstb           asynchronous active-low reset
//   mem_addr       memory bus 0 address (combinational from PC / redirect)
//   mem_wr_ena     always 0, this stage never writes
//   mem_din        always 0
//   mem_rdata      memory read data, valid one cycle after the address
//   redirect_valid one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc    redirect target (misaligned targets are aligned down)
//   inst_valid     queue head holds a valid instruction
//   inst           instruction at queue head
//   inst_pc        address of inst
//   inst_ready     decode accepts the head this cycle
//   fetch_error    sticky flag, set by a misaligned redirect
module mips_fetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = 32'h4000_0000,
  parameter int             Q_DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rstb,
  output logic [N-1:0] mem_addr,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_rdata,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         inst_valid,
  output logic [N-1:0] inst,
  output logic [N-1:0] inst_pc,
  input  logic         inst_ready,
  output logic         fetch_error
);

  localparam logic [1:0] DEPTH = 2'(Q_DEPTH);

  logic [N-1:0] fetch_pc;
  logic         inf_v;
  logic [N-1:0] inf_pc;
  logic         inf_sq;
  logic [1:0]   count;

  // Queue is a two-stage shift register: head feeds decode directly so
  // inst/inst_pc come straight from flops.
  logic [N-1:0] head_inst;
  logic [N-1:0] head_pc;
  logic [N-1:0] tail_inst;
  logic [N-1:0] tail_pc;

  logic         pop;
  logic         wr;
  logic         issue;
  logic [1:0]   occ;
  logic [1:0]   after_pop;

  assign mem_wr_ena = 1'b0;
  assign mem_din    = '0;
  assign inst_valid = (count != 2'd0);
  assign inst       = head_inst;
  assign inst_pc    = head_pc;

  // Issue only when queue plus the in-flight return still fits after this
  // cycle's pop; this is what makes queue overflow impossible. A redirect
  // flushes everything, so it always issues.
  always_comb begin
    pop       = inst_valid & inst_ready;
    wr        = inf_v & ~inf_sq & ~redirect_valid;
    occ       = count + {1'b0, inf_v} - {1'b0, pop};
    after_pop = count - {1'b0, pop};
    issue     = redirect_valid | (occ < DEPTH);
    mem_addr  = redirect_valid ? {redirect_pc[N-1:2], 2'b00} : fetch_pc;
  end

  // Fetch PC, in-flight tracking, queue update and sticky error flag.
  // The returning word lands in the first free slot after the pop, so a
  // simultaneous pop and write leaves count unchanged. inf_sq is cleared on
  // every redirect because a redirect discards the return arriving in its
  // own cycle directly rather than marking it for later.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fetch_pc    <= RESET_PC;
      inf_v       <= 1'b0;
      inf_pc      <= '0;
      inf_sq      <= 1'b0;
      count       <= 2'd0;
      head_inst   <= '0;
      head_pc     <= '0;
      tail_inst   <= '0;
      tail_pc     <= '0;
      fetch_error <= 1'b0;
    end else begin
      if (issue) begin
        inf_v    <= 1'b1;
        inf_pc   <= mem_addr;
        fetch_pc <= mem_addr + N'(4);
      end else begin
        inf_v    <= 1'b0;
      end

      if (redirect_valid) begin
        inf_sq <= 1'b0;
      end

      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        fetch_error <= 1'b1;
      end

      if (pop) begin
        head_inst <= tail_inst;
        head_pc   <= tail_pc;
      end

      if (wr) begin
        if (after_pop == 2'd0) begin
          head_inst <= mem_rdata;
          head_pc   <= inf_pc;
        end else begin
          tail_inst <= mem_rdata;
          tail_pc   <= inf_pc;
        end
      end

      if (redirect_valid) begin
        count <= 2'd0;
      end else begin
        count <= after_pop + {1'b0, wr};
      end
    end
  end

`ifndef SYNTHESIS
  // A write into a queue that is still full after the pop means the issue
  // rule has been broken somewhere.
  always @(posedge clk) begin
    if (rstb) begin
      assert (!(wr && (after_pop >= DEPTH)));
    end
  end
`endif

endmodule
